// File: rtl/inert_disp_pkg.sv
// Shared state encoding and LED pattern helpers for the inertial display sequencer.
package inert_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    DISP = 2'd2,
    ERR  = 2'd3
  } disp_state_t;

  // Patterns are built at the widest supported LED count and sliced by the user.
  localparam int LED_MAX = 64;

  function automatic logic [LED_MAX-1:0] led_mask(input int w);
    return ~({LED_MAX{1'b1}} << w);
  endfunction

  function automatic logic [LED_MAX-1:0] led_idle(input int w);
    return led_mask(w) & {LED_MAX{1'b0}};
  endfunction

  function automatic logic [LED_MAX-1:0] led_cal(input int w);
    return led_mask(w) & {{(LED_MAX-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [LED_MAX-1:0] led_err(input int w);
    return led_mask(w);
  endfunction

endpackage

// File: rtl/seq_wrap_cnt.sv
// Up/down modulo-N counter with synchronous clear; inc and dec together hold the value.
module seq_wrap_cnt #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count with wrap in both directions
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc && !dec) begin
      cnt_d = (cnt_q == LAST) ? {W{1'b0}} : cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = (cnt_q == {W{1'b0}}) ? LAST : cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/inert_disp_seq.sv
// Bring-up display sequencer: starts sensor calibration, watches for timeout, then shows a
// bit slice of the selected channel on the LEDs with manual or timed channel stepping.
module inert_disp_seq
  import inert_disp_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 16,
  parameter int LED_W     = 8,
  parameter int SLICE_LSB = 1,
  parameter int CAL_TO    = 50000000,
  parameter int AUTO_CYC  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       next,
  input  logic                       prev,
  output logic                       strt_cal,
  input  logic                       cal_done,
  input  logic                       vld,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic                       cal_err,
  output logic [LED_W-1:0]           LED
);

  localparam int  CH_W    = $clog2(NUM_CH);
  localparam int  CAL_TW  = ($clog2(CAL_TO + 1) < 1) ? 1 : $clog2(CAL_TO + 1);
  localparam int  AUTO_TW = ($clog2(AUTO_CYC + 1) < 1) ? 1 : $clog2(AUTO_CYC + 1);
  localparam bit  AUTO_EN = (AUTO_CYC > 0);

  localparam logic [CAL_TW-1:0]  CAL_LAST  = CAL_TW'(CAL_TO - 1);
  localparam logic [AUTO_TW-1:0] AUTO_LAST = AUTO_TW'(AUTO_CYC - 1);

  localparam logic [LED_MAX-1:0] LED_IDLE_FULL = led_idle(LED_W);
  localparam logic [LED_MAX-1:0] LED_CAL_FULL  = led_cal(LED_W);
  localparam logic [LED_MAX-1:0] LED_ERR_FULL  = led_err(LED_W);
  localparam logic [LED_W-1:0]   LED_IDLE_V    = LED_IDLE_FULL[LED_W-1:0];
  localparam logic [LED_W-1:0]   LED_CAL_V     = LED_CAL_FULL[LED_W-1:0];
  localparam logic [LED_W-1:0]   LED_ERR_V     = LED_ERR_FULL[LED_W-1:0];

  generate
    if (NUM_CH < 2) begin : g_bad_num_ch
      $error("inert_disp_seq: NUM_CH must be at least 2");
    end
    if (SLICE_LSB + LED_W > DATA_W) begin : g_bad_slice
      $error("inert_disp_seq: LED slice exceeds channel width");
    end
    if (CAL_TO < 1) begin : g_bad_cal_to
      $error("inert_disp_seq: CAL_TO must be at least 1");
    end
  endgenerate

  disp_state_t         state_q,    state_d;
  logic [CAL_TW-1:0]   cal_tmr_q,  cal_tmr_d;
  logic [AUTO_TW-1:0]  auto_tmr_q, auto_tmr_d;
  logic                strt_cal_q, strt_cal_d;
  logic                cal_err_q,  cal_err_d;
  logic                reload_q,   reload_d;
  logic [LED_W-1:0]    led_q,      led_d;

  logic                cnt_clr_s;
  logic                cnt_inc_s;
  logic                cnt_dec_s;
  logic                auto_fire_s;
  logic [CH_W-1:0]     ch_sel_s;
  logic [LED_W-1:0]    slice_s;

  seq_wrap_cnt #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_ch_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .inc (cnt_inc_s),
    .dec (cnt_dec_s),
    .cnt (ch_sel_s)
  );

  assign slice_s     = ch_data[int'(ch_sel_s)*DATA_W + SLICE_LSB +: LED_W];
  // A manual press always wins over the auto-advance timer.
  assign auto_fire_s = AUTO_EN && (state_q == DISP) && !(next || prev) &&
                       (auto_tmr_q == AUTO_LAST);

  // Next state, timers, channel stepping and LED value
  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    strt_cal_d = 1'b0;
    cal_tmr_d  = {CAL_TW{1'b0}};
    auto_tmr_d = {AUTO_TW{1'b0}};
    reload_d   = 1'b0;
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (next) begin
          state_d    = CAL;
          led_d      = LED_CAL_V;
          strt_cal_d = 1'b1;
        end else begin
          led_d = (state_q == ERR) ? LED_ERR_V : LED_IDLE_V;
        end
      end
      CAL: begin
        if (cal_done) begin
          state_d   = DISP;
          cnt_clr_s = 1'b1;
          reload_d  = 1'b1;
        end else if (cal_tmr_q == CAL_LAST) begin
          state_d = ERR;
          led_d   = LED_ERR_V;
        end else begin
          cal_tmr_d = cal_tmr_q + 1'b1;
        end
      end
      DISP: begin
        if (vld || reload_q) begin
          led_d = slice_s;
        end else begin
          led_d = led_q;
        end
        if (next || prev || auto_fire_s) begin
          auto_tmr_d = {AUTO_TW{1'b0}};
        end else if (AUTO_EN) begin
          auto_tmr_d = auto_tmr_q + 1'b1;
        end else begin
          auto_tmr_d = {AUTO_TW{1'b0}};
        end
        cnt_inc_s = next || auto_fire_s;
        cnt_dec_s = prev;
        reload_d  = cnt_inc_s ^ cnt_dec_s;
      end
      default: begin
        state_d = IDLE;
        led_d   = LED_IDLE_V;
      end
    endcase
    cal_err_d = (state_d == ERR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cal_tmr_q  <= {CAL_TW{1'b0}};
      auto_tmr_q <= {AUTO_TW{1'b0}};
      strt_cal_q <= 1'b0;
      cal_err_q  <= 1'b0;
      reload_q   <= 1'b0;
      led_q      <= {LED_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cal_tmr_q  <= cal_tmr_d;
      auto_tmr_q <= auto_tmr_d;
      strt_cal_q <= strt_cal_d;
      cal_err_q  <= cal_err_d;
      reload_q   <= reload_d;
      led_q      <= led_d;
    end
  end

  assign strt_cal = strt_cal_q;
  assign cal_err  = cal_err_q;
  assign ch_sel   = ch_sel_s;
  assign LED      = led_q;

endmodule
